// File: rtl/uart_apb_regs_pkg.sv
// Shared definitions for the UART APB register front-end.
// Holds register offsets, field bit positions, reset constants,
// the CFG payload struct and a CFG validity helper.
package uart_regs_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BAUD_W = 20;
    localparam int unsigned DLEN_W = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ERR_W  = 4;
    localparam int unsigned IEN_W  = 3;
    localparam int unsigned CFG_W  = 27;

    // Register byte offsets
    localparam logic [ADDR_W-1:0] ADDR_DATA = 5'h00;
    localparam logic [ADDR_W-1:0] ADDR_CFG  = 5'h04;
    localparam logic [ADDR_W-1:0] ADDR_STAT = 5'h08;
    localparam logic [ADDR_W-1:0] ADDR_ERR  = 5'h0C;
    localparam logic [ADDR_W-1:0] ADDR_IEN  = 5'h10;

    // CFG field positions (mirrored by cfg_t layout)
    localparam int unsigned CFG_BAUD_LSB    = 0;
    localparam int unsigned CFG_DLEN_LSB    = 20;
    localparam int unsigned CFG_CHECK_BIT   = 24;
    localparam int unsigned CFG_STCHECK_BIT = 25;
    localparam int unsigned CFG_PARITY_BIT  = 26;

    // STATUS field positions
    localparam int unsigned STAT_RXCNT_LSB   = 0;
    localparam int unsigned STAT_TXCNT_LSB   = 5;
    localparam int unsigned STAT_RXEMPTY_BIT = 10;
    localparam int unsigned STAT_TXFULL_BIT  = 11;
    localparam int unsigned STAT_RXWORK_BIT  = 12;
    localparam int unsigned STAT_TXWORK_BIT  = 13;

    // ERR field positions
    localparam int unsigned ERR_PAR_BIT   = 0;
    localparam int unsigned ERR_STOP_BIT  = 1;
    localparam int unsigned ERR_TXOVF_BIT = 2;
    localparam int unsigned ERR_RXUNF_BIT = 3;

    // IRQ_EN field positions
    localparam int unsigned IEN_RX_BIT  = 0;
    localparam int unsigned IEN_TX_BIT  = 1;
    localparam int unsigned IEN_ERR_BIT = 2;

    // Reset and legal-range constants
    localparam logic [DLEN_W-1:0] RST_DLEN    = 4'd8;
    localparam logic              RST_CHECK   = 1'b1;
    localparam logic              RST_STCHECK = 1'b1;
    localparam logic              RST_PARITY  = 1'b0;
    localparam logic [DLEN_W-1:0] DLEN_MIN    = 4'd5;
    localparam logic [DLEN_W-1:0] DLEN_MAX    = 4'd8;

    // CFG register payload, packed in register bit order (bit 0 = baud LSB)
    typedef struct packed {
        logic              parity;
        logic              st_check;
        logic              check;
        logic [DLEN_W-1:0] dlen;
        logic [BAUD_W-1:0] baud;
    } cfg_t;

    // A CFG write is accepted only as a whole and only with sane framing/baud
    function automatic logic cfg_valid(input cfg_t c);
        return (c.dlen >= DLEN_MIN) && (c.dlen <= DLEN_MAX) && (c.baud != '0);
    endfunction

endpackage

// File: rtl/uart_apb_regs_if.sv
// APB3 completer-side bus bundle for the UART register block.
// Ports: psel/penable/pwrite/paddr/pwdata from the requester,
// prdata/pready/pslverr back from the completer.
interface uart_apb_regs_if;
    import uart_regs_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/uart_err_latch.sv
// Registered acknowledge plus sticky W1C flag for one UART line error.
// Ports: clk, rstn; err_in (raw UART error level), clr (software W1C);
// ack (err_in delayed one cycle), sticky (set by err_in, cleared by clr).
module uart_err_latch (
    input  logic clk,
    input  logic rstn,
    input  logic err_in,
    input  logic clr,
    output logic ack,
    output logic sticky
);

    // A set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack    <= 1'b0;
            sticky <= 1'b0;
        end else begin
            ack <= err_in;
            if (err_in) begin
                sticky <= 1'b1;
            end else if (clr) begin
                sticky <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_apb_regs.sv
// APB3 register front-end for the UART core.
// Ports: clk, rstn; apb (APB3 slave bundle, zero wait state);
// UART controls uart_buad/data_length/check/st_check/parity,
// TX push tx_in_data/tx_fifo_write, RX pop rx_fifo_read,
// error acks p_error_ack/st_error_ack; UART status inputs
// data_to_reg, rx/tx_fifo_cnt, rx_fifo_empty, tx_fifo_full,
// rx_work, tx_work, p_error, st_error; level interrupt irq.
module uart_apb_regs
    import uart_regs_pkg::*;
#(
    parameter int unsigned        CLK_FREQ = 50_000_000,
    parameter logic [BAUD_W-1:0]  RST_BAUD = 20'd115200
) (
    input  logic              clk,
    input  logic              rstn,
    uart_apb_regs_if.slave    apb,
    output logic [BAUD_W-1:0] uart_buad,
    output logic [DLEN_W-1:0] data_length,
    output logic              check,
    output logic              st_check,
    output logic              parity,
    output logic [BYTE_W-1:0] tx_in_data,
    output logic              tx_fifo_write,
    output logic              rx_fifo_read,
    output logic              p_error_ack,
    output logic              st_error_ack,
    input  logic [BYTE_W-1:0] data_to_reg,
    input  logic [CNT_W-1:0]  rx_fifo_cnt,
    input  logic [CNT_W-1:0]  tx_fifo_cnt,
    input  logic              rx_fifo_empty,
    input  logic              tx_fifo_full,
    input  logic              rx_work,
    input  logic              tx_work,
    input  logic              p_error,
    input  logic              st_error,
    output logic              irq
);

    // CLK_FREQ is informational only; this empty block just names it at elaboration
    if (CLK_FREQ == 0) begin : g_clk_freq_unset
    end

    localparam cfg_t CFG_RST = '{
        parity:   RST_PARITY,
        st_check: RST_STCHECK,
        check:    RST_CHECK,
        dlen:     RST_DLEN,
        baud:     RST_BAUD
    };

    cfg_t              cfg;
    logic [IEN_W-1:0]  ien;
    logic              tx_ovf;
    logic              rx_unf;
    logic              par_sticky;
    logic              stop_sticky;
    logic [ERR_W-1:0]  err_c;
    logic [DATA_W-1:0] stat_c;

    logic              access_c;
    logic [ADDR_W-1:0] word_addr_c;
    cfg_t              cfg_wr_c;
    logic [DATA_W-1:0] prdata_c;
    logic              pslverr_c;
    logic              push_c;
    logic              pop_c;
    logic              ovf_set_c;
    logic              unf_set_c;
    logic              cfg_we_c;
    logic              ien_we_c;
    logic [ERR_W-1:0]  err_clr_c;
    logic              irq_c;

    // Bits that carry no register meaning
    logic unused_bits;
    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata[DATA_W-1:CFG_W]};

    assign access_c    = apb.psel & apb.penable;
    assign word_addr_c = {apb.paddr[ADDR_W-1:2], 2'b00};
    assign cfg_wr_c    = cfg_t'(apb.pwdata[CFG_W-1:0]);

    assign apb.prdata  = prdata_c;
    assign apb.pslverr = pslverr_c;
    assign apb.pready  = 1'b1;

    // UART control ports come straight from the CFG register
    assign uart_buad   = cfg.baud;
    assign data_length = cfg.dlen;
    assign check       = cfg.check;
    assign st_check    = cfg.st_check;
    assign parity      = cfg.parity;

    // STATUS and ERR read views
    always_comb begin
        stat_c = '0;
        stat_c[STAT_RXCNT_LSB +: CNT_W] = rx_fifo_cnt;
        stat_c[STAT_TXCNT_LSB +: CNT_W] = tx_fifo_cnt;
        stat_c[STAT_RXEMPTY_BIT]        = rx_fifo_empty;
        stat_c[STAT_TXFULL_BIT]         = tx_fifo_full;
        stat_c[STAT_RXWORK_BIT]         = rx_work;
        stat_c[STAT_TXWORK_BIT]         = tx_work;

        err_c = '0;
        err_c[ERR_PAR_BIT]   = par_sticky;
        err_c[ERR_STOP_BIT]  = stop_sticky;
        err_c[ERR_TXOVF_BIT] = tx_ovf;
        err_c[ERR_RXUNF_BIT] = rx_unf;
    end

    // Access decode: read mux, error response and register strobes
    always_comb begin
        prdata_c  = '0;
        pslverr_c = 1'b0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        ovf_set_c = 1'b0;
        unf_set_c = 1'b0;
        cfg_we_c  = 1'b0;
        ien_we_c  = 1'b0;
        err_clr_c = '0;

        if (access_c) begin
            case (word_addr_c)
                ADDR_DATA: begin
                    if (apb.pwrite) begin
                        if (tx_fifo_full) begin
                            pslverr_c = 1'b1;
                            ovf_set_c = 1'b1;
                        end else begin
                            push_c = 1'b1;
                        end
                    end else begin
                        if (rx_fifo_empty) begin
                            pslverr_c = 1'b1;
                            unf_set_c = 1'b1;
                        end else begin
                            prdata_c = DATA_W'(data_to_reg);
                            pop_c    = 1'b1;
                        end
                    end
                end
                ADDR_CFG: begin
                    if (apb.pwrite) begin
                        if (cfg_valid(cfg_wr_c)) begin
                            cfg_we_c = 1'b1;
                        end else begin
                            pslverr_c = 1'b1;
                        end
                    end else begin
                        prdata_c = DATA_W'(cfg);
                    end
                end
                ADDR_STAT: begin
                    if (!apb.pwrite) begin
                        prdata_c = stat_c;
                    end
                end
                ADDR_ERR: begin
                    if (apb.pwrite) begin
                        err_clr_c = apb.pwdata[ERR_W-1:0];
                    end else begin
                        prdata_c = DATA_W'(err_c);
                    end
                end
                ADDR_IEN: begin
                    if (apb.pwrite) begin
                        ien_we_c = 1'b1;
                    end else begin
                        prdata_c = DATA_W'(ien);
                    end
                end
                default: begin
                    pslverr_c = 1'b1;
                end
            endcase
        end
    end

    // Interrupt sources before the output register
    assign irq_c = (ien[IEN_RX_BIT]  & ~rx_fifo_empty)
                 | (ien[IEN_TX_BIT]  & (tx_fifo_cnt == '0) & ~tx_work)
                 | (ien[IEN_ERR_BIT] & (|err_c));

    // Configuration, enables, TX data latch and one-cycle FIFO strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg           <= CFG_RST;
            ien           <= '0;
            tx_in_data    <= '0;
            tx_fifo_write <= 1'b0;
            rx_fifo_read  <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (cfg_we_c) begin
                cfg <= cfg_wr_c;
            end
            if (ien_we_c) begin
                ien <= apb.pwdata[IEN_W-1:0];
            end
            if (push_c) begin
                tx_in_data <= apb.pwdata[BYTE_W-1:0];
            end
            tx_fifo_write <= push_c;
            rx_fifo_read  <= pop_c;
            irq           <= irq_c;
        end
    end

    // Sticky software-side FIFO errors; set wins over W1C
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
        end else begin
            if (ovf_set_c) begin
                tx_ovf <= 1'b1;
            end else if (err_clr_c[ERR_TXOVF_BIT]) begin
                tx_ovf <= 1'b0;
            end
            if (unf_set_c) begin
                rx_unf <= 1'b1;
            end else if (err_clr_c[ERR_RXUNF_BIT]) begin
                rx_unf <= 1'b0;
            end
        end
    end

    uart_err_latch u_par_err (
        .clk    (clk),
        .rstn   (rstn),
        .err_in (p_error),
        .clr    (err_clr_c[ERR_PAR_BIT]),
        .ack    (p_error_ack),
        .sticky (par_sticky)
    );

    uart_err_latch u_stop_err (
        .clk    (clk),
        .rstn   (rstn),
        .err_in (st_error),
        .clr    (err_clr_c[ERR_STOP_BIT]),
        .ack    (st_error_ack),
        .sticky (stop_sticky)
    );

endmodule

// File: tb/tb_uart_apb_regs.sv
// Self-checking bench for uart_apb_regs: a table of register accesses
// plus hand-written TX/RX/error/IRQ/reset sequences against a small
// behavioural UART FIFO model.
module tb_uart_apb_regs;
    import uart_regs_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_apb_regs_if bus ();

    logic [19:0] uart_buad;
    logic [3:0]  data_length;
    logic        check, st_check, parity;
    logic [7:0]  tx_in_data;
    logic        tx_fifo_write, rx_fifo_read;
    logic        p_error_ack, st_error_ack;
    logic [7:0]  data_to_reg;
    logic [4:0]  rx_fifo_cnt, tx_fifo_cnt;
    logic        rx_fifo_empty, tx_fifo_full;
    logic        rx_work = 1'b0, tx_work = 1'b0;
    logic        p_error = 1'b0, st_error = 1'b0;
    logic        irq;

    uart_apb_regs dut (
        .clk           (clk),
        .rstn          (rstn),
        .apb           (bus),
        .uart_buad     (uart_buad),
        .data_length   (data_length),
        .check         (check),
        .st_check      (st_check),
        .parity        (parity),
        .tx_in_data    (tx_in_data),
        .tx_fifo_write (tx_fifo_write),
        .rx_fifo_read  (rx_fifo_read),
        .p_error_ack   (p_error_ack),
        .st_error_ack  (st_error_ack),
        .data_to_reg   (data_to_reg),
        .rx_fifo_cnt   (rx_fifo_cnt),
        .tx_fifo_cnt   (tx_fifo_cnt),
        .rx_fifo_empty (rx_fifo_empty),
        .tx_fifo_full  (tx_fifo_full),
        .rx_work       (rx_work),
        .tx_work       (tx_work),
        .p_error       (p_error),
        .st_error      (st_error),
        .irq           (irq)
    );

    // Behavioural UART FIFOs
    logic [7:0] rx_mem [0:31];
    int         rx_wr = 0;
    int         rx_rd = 0;
    int         tx_cnt = 0;
    logic       tx_drain = 1'b0;
    int         push_cnt = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_tx [$];
    logic [7:0] got_tx [$];

    assign rx_fifo_empty = (rx_wr == rx_rd);
    assign data_to_reg   = rx_mem[5'(rx_rd)];
    assign rx_fifo_cnt   = 5'(rx_wr - rx_rd);
    assign tx_fifo_cnt   = 5'(tx_cnt);
    assign tx_fifo_full  = (tx_cnt >= 16);

    always @(posedge clk) begin
        if (tx_drain) begin
            tx_cnt <= 0;
        end else if (tx_fifo_write) begin
            tx_cnt   <= tx_cnt + 1;
            push_cnt <= push_cnt + 1;
            got_tx.push_back(tx_in_data);
        end
        if (rx_fifo_read) begin
            rx_rd   <= rx_rd + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        @(negedge clk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wd;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        rd  = bus.prdata;
        err = bus.pslverr;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic acc(input string name, input logic wr, input logic [4:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb(wr, addr, wd, rd, err);
        chk({name, "_data"}, rd, exp_rd);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vt [$];

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        for (int i = 0; i < 32; i++) rx_mem[i] = 8'(i);

        vt.push_back('{"cfg_reset",    1'b0, 5'h04, 32'h0,        32'h0381C200, 1'b0});
        vt.push_back('{"stat_reset",   1'b0, 5'h08, 32'h0,        32'h00000400, 1'b0});
        vt.push_back('{"err_reset",    1'b0, 5'h0C, 32'h0,        32'h0,        1'b0});
        vt.push_back('{"ien_reset",    1'b0, 5'h10, 32'h0,        32'h0,        1'b0});
        vt.push_back('{"unmap_rd",     1'b0, 5'h14, 32'h0,        32'h0,        1'b1});
        vt.push_back('{"unmap_wr",     1'b1, 5'h1C, 32'hFFFFFFFF, 32'h0,        1'b1});
        vt.push_back('{"cfg_lowaddr",  1'b0, 5'h07, 32'h0,        32'h0381C200, 1'b0});
        vt.push_back('{"cfg_dlen4",    1'b1, 5'h04, 32'h03402580, 32'h0,        1'b1});
        vt.push_back('{"cfg_dlen9",    1'b1, 5'h04, 32'h03902580, 32'h0,        1'b1});
        vt.push_back('{"cfg_baud0",    1'b1, 5'h04, 32'h07700000, 32'h0,        1'b1});
        vt.push_back('{"cfg_kept",     1'b0, 5'h04, 32'h0,        32'h0381C200, 1'b0});
        vt.push_back('{"cfg_dlen5",    1'b1, 5'h04, 32'h00500001, 32'h0,        1'b0});
        vt.push_back('{"cfg_rd5",      1'b0, 5'h04, 32'h0,        32'h00500001, 1'b0});
        vt.push_back('{"cfg_dlen7",    1'b1, 5'h04, 32'hFD702580, 32'h0,        1'b0});
        vt.push_back('{"cfg_rd7",      1'b0, 5'h04, 32'h0,        32'h05702580, 1'b0});
        vt.push_back('{"stat_wr",      1'b1, 5'h08, 32'hFFFFFFFF, 32'h0,        1'b0});
        vt.push_back('{"stat_rd",      1'b0, 5'h08, 32'h0,        32'h00000400, 1'b0});
        vt.push_back('{"ien_wr",       1'b1, 5'h10, 32'hFFFFFFFF, 32'h0,        1'b0});
        vt.push_back('{"ien_rd",       1'b0, 5'h10, 32'h0,        32'h00000007, 1'b0});
        vt.push_back('{"ien_clr",      1'b1, 5'h10, 32'h0,        32'h0,        1'b0});
        vt.push_back('{"err_w1c_nop",  1'b1, 5'h0C, 32'hF,        32'h0,        1'b0});

        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Reset state of the UART-facing ports
        chk("rst_baud",  32'(uart_buad), 32'd115200);
        chk("rst_dlen",  32'(data_length), 32'd8);
        chk("rst_flags", 32'({check, st_check, parity}), 32'b110);
        chk("rst_irq",   32'(irq), 32'd0);
        chk("pready",    32'(bus.pready), 32'd1);

        foreach (vt[i]) acc(vt[i].name, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].err);

        chk("port_baud",  32'(uart_buad), 32'h02580);
        chk("port_dlen",  32'(data_length), 32'd7);
        chk("port_flags", 32'({check, st_check, parity}), 32'b101);

        // TX: 16 accepted bytes, then overflow
        for (int i = 0; i < 16; i++) begin
            exp_tx.push_back(8'(8 + i));
            acc("tx_wr", 1'b1, 5'h00, 32'(8 + i), 32'h0, 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("tx_full_model", 32'(tx_fifo_full), 32'd1);
        acc("tx_ovf_wr", 1'b1, 5'h00, 32'h99, 32'h0, 1'b1);
        repeat (2) @(negedge clk);
        while (exp_tx.size() > 0) begin
            if (got_tx.size() == 0) begin
                chk("tx_missing_push", 32'(exp_tx.pop_front()), 32'hFFFFFFFF);
            end else begin
                chk("tx_push", 32'(got_tx.pop_front()), 32'(exp_tx.pop_front()));
            end
        end
        chk("tx_extra_push", 32'(got_tx.size()), 32'd0);
        chk("tx_push_cnt",   32'(push_cnt), 32'd16);
        chk("tx_last_data",  32'(tx_in_data), 32'h17);
        acc("err_ovf",  1'b0, 5'h0C, 32'h0, 32'h4, 1'b0);
        acc("err_clr4", 1'b1, 5'h0C, 32'h4, 32'h0, 1'b0);
        acc("err_rd0",  1'b0, 5'h0C, 32'h0, 32'h0, 1'b0);

        // RX: 16 bytes waiting, read back in order, then underflow
        rx_wr   = 16;
        rx_work = 1'b1;
        acc("stat_full", 1'b0, 5'h08, 32'h0, 32'h00001A10, 1'b0);
        rx_work = 1'b0;
        for (int i = 0; i < 16; i++) acc("rx_rd", 1'b0, 5'h00, 32'h0, 32'(i), 1'b0);
        repeat (2) @(negedge clk);
        chk("rx_pop_cnt", 32'(pop_cnt), 32'd16);
        acc("rx_unf_rd", 1'b0, 5'h00, 32'h0, 32'h0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rx_no_pop", 32'(pop_cnt), 32'd16);
        acc("err_unf",  1'b0, 5'h0C, 32'h0, 32'h8, 1'b0);
        acc("err_clr8", 1'b1, 5'h0C, 32'h8, 32'h0, 1'b0);

        // Parity error with error interrupt enabled
        tx_drain = 1'b1;
        @(negedge clk);
        tx_drain = 1'b0;
        acc("ien_err", 1'b1, 5'h10, 32'h4, 32'h0, 1'b0);
        @(negedge clk);
        chk("irq_idle", 32'(irq), 32'd0);
        p_error = 1'b1;
        @(negedge clk);
        chk("p_ack_hi", 32'(p_error_ack), 32'd1);
        p_error = 1'b0;
        @(negedge clk);
        chk("p_ack_lo", 32'(p_error_ack), 32'd0);
        chk("irq_par",  32'(irq), 32'd1);
        acc("err_par", 1'b0, 5'h0C, 32'h0, 32'h1, 1'b0);
        acc("err_clr1", 1'b1, 5'h0C, 32'h1, 32'h0, 1'b0);
        chk("irq_lag", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);

        // Stop error, then a set colliding with a clear
        st_error = 1'b1;
        @(negedge clk);
        chk("st_ack_hi", 32'(st_error_ack), 32'd1);
        st_error = 1'b0;
        @(negedge clk);
        chk("st_ack_lo", 32'(st_error_ack), 32'd0);
        p_error = 1'b1;
        acc("err_setwin_clr", 1'b1, 5'h0C, 32'h1, 32'h0, 1'b0);
        p_error = 1'b0;
        acc("err_setwin", 1'b0, 5'h0C, 32'h0, 32'h3, 1'b0);
        acc("err_clrall", 1'b1, 5'h0C, 32'hF, 32'h0, 1'b0);
        acc("err_clean",  1'b0, 5'h0C, 32'h0, 32'h0, 1'b0);

        // TX-idle and RX-available interrupt sources
        acc("ien_tx", 1'b1, 5'h10, 32'h2, 32'h0, 1'b0);
        @(negedge clk);
        chk("irq_txidle", 32'(irq), 32'd1);
        tx_work = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_txbusy", 32'(irq), 32'd0);
        tx_work = 1'b0;
        rx_wr = 17;
        acc("ien_rx", 1'b1, 5'h10, 32'h1, 32'h0, 1'b0);
        @(negedge clk);
        chk("irq_rxavail", 32'(irq), 32'd1);

        // Reset the cycle after a DATA write access
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 5'h00; bus.pwdata = 32'h55;
        @(negedge clk);
        bus.penable = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_no_push", 32'(tx_fifo_write), 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_push_cnt", 32'(push_cnt), 32'd16);
        chk("rst2_got_tx",   32'(got_tx.size()), 32'd0);
        chk("rst2_baud",     32'(uart_buad), 32'd115200);
        chk("rst2_dlen",     32'(data_length), 32'd8);
        chk("rst2_flags",    32'({check, st_check, parity}), 32'b110);
        chk("rst2_txdata",   32'(tx_in_data), 32'd0);
        chk("rst2_strobes",  32'({tx_fifo_write, rx_fifo_read, p_error_ack, st_error_ack}), 32'd0);
        chk("rst2_irq",      32'(irq), 32'd0);
        chk("rst2_prdata",   bus.prdata, 32'd0);
        chk("rst2_pslverr",  32'(bus.pslverr), 32'd0);
        rstn = 1'b1;
        acc("rst2_ien", 1'b0, 5'h10, 32'h0, 32'h0, 1'b0);
        acc("rst2_err", 1'b0, 5'h0C, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
